// File: rtl/fir_pkg.sv
// Shared types and helpers for the time-multiplexed FIR MAC engine.
// Holds default widths, the controller state encoding and the output
// round/saturate function used when a result is emitted.
package fir_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_COEF_W = 16;
  localparam int DEF_TAPS   = 16;

  typedef enum logic [1:0] {IDLE, MAC, OUT} fir_state_t;

  // Round half up, then clamp to the signed range of data_w bits.
  // The accumulator is passed sign-extended to 64 bits so one function
  // serves every parameterisation.
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc,
                                                   input int shift,
                                                   input int data_w);
    logic signed [63:0] rnd;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    rnd = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
    hi  = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (data_w - 1));
    if (rnd > hi) begin
      return hi;
    end else if (rnd < lo) begin
      return lo;
    end else begin
      return rnd;
    end
  endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Purpose: TAPS x COEF_W coefficient register file, cleared on rst.
// Latency: write lands at the next clk edge; read is combinational.
// Backpressure: none; the caller gates we_i (writes only while idle).
// Ports: we_i/waddr_i/wdata_i write port, raddr_i/rdata_o read port.
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter  int COEF_W = DEF_COEF_W,
  parameter  int TAPS   = DEF_TAPS,
  localparam int AW     = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we_i,
  input  logic [AW-1:0]            waddr_i,
  input  logic signed [COEF_W-1:0] wdata_i,
  input  logic [AW-1:0]            raddr_i,
  output logic signed [COEF_W-1:0] rdata_o
);

  logic signed [COEF_W-1:0] coef_q [TAPS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        coef_q[i] <= '0;
      end
    end else if (we_i && (int'(waddr_i) < TAPS)) begin
      // Out-of-range indices (non power-of-two TAPS) are dropped.
      coef_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = coef_q[raddr_i];

endmodule

// File: rtl/fir_mac_engine.sv
// Purpose: single-multiplier FIR; one sample per sample_clk rising edge.
// Latency: y_valid pulses in the cycle after edge E0+TAPS+1 (E0 = rise seen).
// Backpressure: none; a rise while busy is dropped and flagged on overrun.
// Ports: clk/rst (sync, active-high); sample_clk strobe + sample_in;
//        coef_we/coef_addr/coef_wdata coefficient write (idle only);
//        y_out/y_valid result, busy (not IDLE), overrun (dropped sample).
module fir_mac_engine
  import fir_pkg::*;
#(
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int COEF_W    = DEF_COEF_W,
  parameter  int TAPS      = DEF_TAPS,
  parameter  int ACC_W     = DATA_W + COEF_W + $clog2(TAPS),
  parameter  int OUT_SHIFT = 15,
  localparam int AW        = $clog2(TAPS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_clk,
  input  logic signed [DATA_W-1:0] sample_in,
  input  logic                     coef_we,
  input  logic [AW-1:0]            coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
  output logic signed [DATA_W-1:0] y_out,
  output logic                     y_valid,
  output logic                     busy,
  output logic                     overrun
);

  fir_state_t               state_q, state_d;
  logic                     sample_clk_q;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [AW-1:0]            k_q, k_d;
  logic [AW-1:0]            wptr_q, wptr_d;
  logic [AW-1:0]            newest_q, newest_d;
  logic signed [DATA_W-1:0] y_q, y_d;
  logic                     y_valid_q, y_valid_d;
  logic                     overrun_q, overrun_d;
  logic                     dl_we;
  logic signed [DATA_W-1:0] delay_q [TAPS];

  logic                     rise;
  logic [AW:0]              idx_sum;
  logic [AW:0]              idx_wrap;
  logic [AW-1:0]            tap_idx;
  logic signed [DATA_W-1:0] x_tap;
  logic signed [COEF_W-1:0] h_tap;
  logic signed [DATA_W+COEF_W-1:0] prod;
  logic [AW-1:0]            wptr_next;

  // sample_clk already lives in the clk domain; a single register suffices.
  assign rise = sample_clk & ~sample_clk_q;

  // x[k] = delay[(newest - k) mod TAPS], done with one extra bit so that
  // any TAPS (not only powers of two) wraps correctly.
  assign idx_sum  = {1'b0, newest_q} + (AW+1)'(TAPS) - {1'b0, k_q};
  assign idx_wrap = (idx_sum >= (AW+1)'(TAPS)) ? idx_sum - (AW+1)'(TAPS) : idx_sum;
  assign tap_idx  = idx_wrap[AW-1:0];
  assign x_tap    = delay_q[tap_idx];
  assign prod     = x_tap * h_tap;

  assign wptr_next = (wptr_q == AW'(TAPS - 1)) ? '0 : wptr_q + AW'(1);

  fir_coef_bank #(
    .COEF_W (COEF_W),
    .TAPS   (TAPS)
  ) u_coef_bank (
    .clk     (clk),
    .rst     (rst),
    .we_i    (coef_we && (state_q == IDLE)),
    .waddr_i (coef_addr),
    .wdata_i (coef_wdata),
    .raddr_i (k_q),
    .rdata_o (h_tap)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    k_d       = k_q;
    wptr_d    = wptr_q;
    newest_d  = newest_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
    overrun_d = 1'b0;
    dl_we     = 1'b0;

    case (state_q)
      IDLE: begin
        if (rise) begin
          dl_we    = 1'b1;
          newest_d = wptr_q;
          wptr_d   = wptr_next;
          acc_d    = '0;
          k_d      = '0;
          state_d  = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + ACC_W'(prod);
        if (k_q == AW'(TAPS - 1)) begin
          k_d     = '0;
          state_d = OUT;
        end else begin
          k_d = k_q + AW'(1);
        end
      end
      OUT: begin
        y_d       = DATA_W'(sat_round(64'(acc_q), OUT_SHIFT, DATA_W));
        y_valid_d = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A rise that cannot be accepted is dropped; the running MAC continues.
    if (rise && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sample_clk_q <= 1'b0;
      acc_q        <= '0;
      k_q          <= '0;
      wptr_q       <= '0;
      newest_q     <= '0;
      y_q          <= '0;
      y_valid_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_clk_q <= sample_clk;
      acc_q        <= acc_d;
      k_q          <= k_d;
      wptr_q       <= wptr_d;
      newest_q     <= newest_d;
      y_q          <= y_d;
      y_valid_q    <= y_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        delay_q[i] <= '0;
      end
    end else if (dl_we) begin
      delay_q[wptr_q] <= sample_in;
    end
  end

  assign y_out   = y_q;
  assign y_valid = y_valid_q;
  assign busy    = (state_q != IDLE);
  assign overrun = overrun_q;

endmodule
